// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants and types.
// Used by vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

   localparam int COORD_W = 10;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FP_DEF      = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BP_DEF      = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FP_DEF      = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BP_DEF      = 33;

   localparam int H_TOTAL_DEF =
      H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF =
      V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   typedef logic [COORD_W-1:0] vga_coord_t;

   // Per-pixel decode bundle, registered as a unit.
   typedef struct packed {
      logic blank;
      logic hs;
      logic vs;
      logic line_start;
      logic frame_start;
   } vga_flags_t;

   localparam vga_flags_t FLAGS_RST = '{
      blank:       1'b1,
      hs:          1'b1,
      vs:          1'b1,
      line_start:  1'b1,
      frame_start: 1'b1
   };

   // True when lo <= v < hi.
   function automatic logic in_span(
      input vga_coord_t v,
      input vga_coord_t lo,
      input vga_coord_t hi
   );
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis, wraps TOTAL-1 -> 0.
// Exposes its next-state value so decodes can be registered in step.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL = H_TOTAL_DEF
) (
   input  logic       vga_clk,
   input  logic       Reset,
   input  logic       en_i,
   output vga_coord_t count_o,
   output vga_coord_t next_o,
   output logic       tc_o
);

   localparam vga_coord_t LAST = vga_coord_t'(TOTAL - 1);

   vga_coord_t count_q;
   vga_coord_t count_d;

   assign tc_o    = (count_q == LAST);
   assign count_o = count_q;
   assign next_o  = count_d;

   // Next count: reset wins, then advance/wrap when enabled.
   always_comb begin
      count_d = count_q;
      if (Reset) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = tc_o ? '0 : count_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (DrawX/DrawY, blank, syncs).
// Define VGA_SYNC_DELAY_EN to delay hs/vs one cycle to match registered RGB.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FP      = H_FP_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BP      = H_BP_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FP      = V_FP_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BP      = V_BP_DEF
) (
   input  logic        vga_clk,
   input  logic        Reset,
   output vga_coord_t  DrawX,
   output vga_coord_t  DrawY,
   output logic        blank,
   output logic        hs,
   output logic        vs,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam vga_coord_t H_VIS_END = vga_coord_t'(H_VISIBLE);
   localparam vga_coord_t V_VIS_END = vga_coord_t'(V_VISIBLE);
   localparam vga_coord_t HS_LO = vga_coord_t'(H_VISIBLE + H_FP);
   localparam vga_coord_t HS_HI = vga_coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam vga_coord_t VS_LO = vga_coord_t'(V_VISIBLE + V_FP);
   localparam vga_coord_t VS_HI = vga_coord_t'(V_VISIBLE + V_FP + V_SYNC);

   vga_coord_t hc;
   vga_coord_t vc;
   vga_coord_t hc_d;
   vga_coord_t vc_d;
   logic       h_tc;
   logic       v_tc;

   vga_flags_t  flags_q;
   vga_flags_t  flags_d;
   logic [15:0] frame_cnt_q;
   logic [15:0] frame_cnt_d;
   logic        frame_wrap;

   vga_axis_counter #(
      .TOTAL (H_TOTAL)
   ) u_hcnt (
      .vga_clk (vga_clk),
      .Reset   (Reset),
      .en_i    (1'b1),
      .count_o (hc),
      .next_o  (hc_d),
      .tc_o    (h_tc)
   );

   vga_axis_counter #(
      .TOTAL (V_TOTAL)
   ) u_vcnt (
      .vga_clk (vga_clk),
      .Reset   (Reset),
      .en_i    (h_tc),
      .count_o (vc),
      .next_o  (vc_d),
      .tc_o    (v_tc)
   );

   assign frame_wrap = h_tc && v_tc;

   // Decode flags from next-state counters so they align with DrawX/DrawY.
   always_comb begin
      flags_d             = FLAGS_RST;
      flags_d.blank       = (hc_d < H_VIS_END) && (vc_d < V_VIS_END);
      flags_d.hs          = !in_span(hc_d, HS_LO, HS_HI);
      flags_d.vs          = !in_span(vc_d, VS_LO, VS_HI);
      flags_d.line_start  = (hc_d == '0);
      flags_d.frame_start = (hc_d == '0) && (vc_d == '0);
   end

   // Completed-frame count, steps on the (H_TOTAL-1, V_TOTAL-1) edge.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_wrap) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   // Registered flags and frame counter.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         flags_q     <= FLAGS_RST;
         frame_cnt_q <= '0;
      end else begin
         flags_q     <= flags_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   logic hs_dly_q;
   logic vs_dly_q;

   // Extra sync stage so hs/vs land with the renderer's registered RGB.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         hs_dly_q <= 1'b1;
         vs_dly_q <= 1'b1;
      end else begin
         hs_dly_q <= flags_q.hs;
         vs_dly_q <= flags_q.vs;
      end
   end

   assign hs = hs_dly_q;
   assign vs = vs_dly_q;
`else
   assign hs = flags_q.hs;
   assign vs = flags_q.vs;
`endif

   assign DrawX       = hc;
   assign DrawY       = vc;
   assign blank       = flags_q.blank;
   assign line_start  = flags_q.line_start;
   assign frame_start = flags_q.frame_start;
   assign frame_count = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-clock raster timing generator for the 640x480 @ 60 Hz display path. It produces the `DrawX`/`DrawY` scan coordinates and the active-high `blank` (display-enable) that every sprite/ROM renderer consumes. It also drives the monitor's horizontal and vertical sync, plus frame/line markers for game-state logic. It sits at the top of the video pipeline, upstream of all sprite examples and the compositing mux.

## Interface

Parameters:
- `H_VISIBLE`, default 640: visible pixels per line
- `H_FP`, default 16: horizontal front porch, in pixels
- `H_SYNC`, default 96: horizontal sync width, in pixels
- `H_BP`, default 48: horizontal back porch, in pixels
- `V_VISIBLE`, default 480: visible lines
- `V_FP`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vertical sync width, in lines
- `V_BP`, default 33: vertical back porch, in lines

Ports (one clock; reset is synchronous and active-high):
- `vga_clk`, in, 1: pixel clock (25 MHz nominal); all state on posedge
- `Reset`, in, 1: synchronous, active-high
- `DrawX`, out, 10: current horizontal position, 0..H_TOTAL-1
- `DrawY`, out, 10: current vertical position, 0..V_TOTAL-1
- `blank`, out, 1: 1 = visible region (draw), 0 = porch/sync
- `hs`, out, 1: horizontal sync, active-low
- `vs`, out, 1: vertical sync, active-low
- `line_start`, out, 1: high for the one cycle where DrawX == 0
- `frame_start`, out, 1: high for the one cycle where DrawX == 0 and DrawY == 0
- `frame_count`, out, 16: completed-frame counter

## Operation

- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Horizontal counter `hc` increments every cycle and wraps H_TOTAL-1 -> 0.
- Vertical counter `vc` increments only on an `hc` wrap and wraps V_TOTAL-1 -> 0.
- Counter widths are 10 bits. No state is reachable beyond the totals.
- `DrawX` = `hc` and `DrawY` = `vc`, both direct register outputs.
- `blank` = (hc < H_VISIBLE) && (vc < V_VISIBLE).
- `hs` = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC, which is 656..751 at the defaults.
- `vs` = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC, which is 490..491 at the defaults.
- `hs`, `vs` and `blank` are registered. They are computed from the next-state counter values, so each is cycle-aligned with the `DrawX`/`DrawY` it describes.
- `frame_count` increments by 1 on the cycle where the counters step from (H_TOTAL-1, V_TOTAL-1) to (0,0). It wraps 0xFFFF -> 0x0000.
- Reset values: hc = vc = 0, so `DrawX` = `DrawY` = 0. `blank` = 1, `hs` = 1, `vs` = 1, `line_start` = 1, `frame_start` = 1, `frame_count` = 0.
- Reset mid-frame: on the cycle after `Reset` is sampled high, all outputs hold their reset values regardless of prior position. Scanning resumes from (0,0) on the first cycle `Reset` is low.
- Simultaneous events: at (H_TOTAL-1, V_TOTAL-1), the `hc` wrap, `vc` wrap and `frame_count` increment all occur on the same edge.

## Timing

- Steady state: exactly one pixel per `vga_clk`.
- Line period is 800 cycles. Frame period is 420000 cycles.
- Latency from a counter value to its `blank`/`hs`/`vs` decode: 0 cycles. All of these outputs change on the same edge.
- The downstream renderer registers RGB one cycle after `DrawX`. Sync alignment with that delayed pixel is handled under Configuration.

## Configuration

- `VGA_SYNC_DELAY_EN`, when defined:
  - `hs` and `vs` pass through one additional register stage (reset value 1).
  - Sync then lands on the same edge as the renderer's registered RGB. At the defaults, `hs` falls on the cycle where DrawX == 657.
  - `blank`, `DrawX`, `DrawY`, `line_start`, `frame_start` and `frame_count` are unaffected.
- Undefined: `hs` and `vs` are aligned with `DrawX`/`DrawY`, so `hs` falls when DrawX == 656.

## Structure

- Package `vga_timing_pkg`:
  - default 640x480 timing constants
  - derived H_TOTAL/V_TOTAL
  - coordinate typedef `vga_coord_t` (logic [9:0])
- Sub-module `vga_axis_counter`, instantiated twice (horizontal, vertical):
  - parameterised by total count
  - inputs: `vga_clk`, `Reset`, count enable
  - outputs: count and terminal-count flag
  - the vertical instance is enabled by the horizontal terminal count

## Test plan

- Reset hold for 5 cycles, then release -> first cycle shows DrawX = 0, DrawY = 0, blank = 1, hs = 1, vs = 1, frame_start = 1, frame_count = 0.
- Run one line -> blank = 1 at DrawX = 639 and 0 at 640; hs low for exactly 96 cycles (DrawX 656..751); DrawX goes 799 -> 0 while DrawY goes 0 -> 1; line_start pulses at that step.
- Run one full frame -> vs low only on DrawY 490..491 (1600 cycles); blank stays 0 for all of DrawY >= 480.
- At (799, 524) -> next cycle is (0,0), frame_start = 1 and frame_count = 1. Run 65536 frames, or force the counter to 0xFFFF -> frame_count wraps to 0.
- Assert Reset at DrawX = 300, DrawY = 200 -> next cycle every output is at its reset value, and scanning restarts from (0,0) after release.
- With `VGA_SYNC_DELAY_EN` defined -> hs falls at DrawX = 657 and vs falls at DrawX = 1 of line 490; blank timing is identical to the undefined build.
